matrix_loader: RTL and testbench
================================

Name: matrix_loader

Overview:
- Upstream stage for the matrix multiplier.
- Accepts a serial word stream over a valid/ready handshake. The stream is one header word carrying the dimensions, followed by the matrix 1 elements, then the matrix 2 elements, all row-major.
- Packs the elements into flat buffers, validates the dimensions, then presents the flat buffers plus R1/C1/R2/C2 to the multiplier. It raises readybit and holds everything stable until the multiplier acknowledges with startbit.

Parameters:
- DATA_W, 32, element width in bits; also the width of in_data.
- MAX_ELEMS, 4, depth of each flat buffer; the largest allowed R*C per matrix.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  stream word: header or element.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a word; a transfer happens when in_valid and in_ready are both high at a rising edge.
- flat_matrix_1  output  DATA_W x [0:MAX_ELEMS-1]  matrix 1 elements, row-major.
- flat_matrix_2  output  DATA_W x [0:MAX_ELEMS-1]  matrix 2 elements, row-major.
- R1, C1, R2, C2  output  4 each  latched dimensions.
- readybit  output  1  a complete, valid operand set is presented.
- startbit  input  1  acknowledge from the multiplier.
- hdr_err  output  1  one-cycle pulse: header rejected.
- busy  output  1  high in every state other than IDLE.

Behaviour:
Reset (RST_N low, asynchronous):
- State goes to IDLE.
- in_ready=0, readybit=0, hdr_err=0, busy=0.
- R1, C1, R2 and C2 are cleared to 0; every flat_matrix entry is cleared to 0.
- in_ready rises on the first clock edge after RST_N is released.

States: IDLE, LOAD1, LOAD2, PRESENT.

IDLE:
- in_ready=1.
- A transfer in this state is the header. Header fields: R1=in_data[3:0], C1=[7:4], R2=[11:8], C2=[15:12]. Bits [DATA_W-1:16] are ignored.
- The header is valid only when all of the following hold:
  - all four fields are nonzero;
  - R1*C1 <= MAX_ELEMS;
  - R2*C2 <= MAX_ELEMS;
  - C1 == R2.
- Valid header, at the same edge:
  - latch the dimensions;
  - clear both buffers to 0;
  - reset the element index to 0;
  - go to LOAD1.
- Invalid header:
  - hdr_err=1 for exactly the next cycle;
  - dimension outputs and buffers are left unchanged;
  - stay in IDLE; the next transferred word is treated as a new header.

LOAD1:
- in_ready=1.
- Each transfer writes flat_matrix_1[idx] and increments idx.
- On the transfer with idx == R1*C1-1: reset idx to 0 and go to LOAD2.
- Cycles without a transfer (in_valid low) hold all state.

LOAD2:
- Same as LOAD1, writing flat_matrix_2 and ending at R2*C2-1.
- The last transfer moves to PRESENT; readybit=1 from the next cycle.

PRESENT:
- in_ready=0; readybit=1.
- Buffers and dimensions are held stable.
- On the first edge where startbit=1: readybit=0 in the following cycle and the state returns to IDLE.
- Buffers and dimensions keep their values until the next valid header, so the multiplier may read them after acknowledging.
- With startbit held low, the loader waits indefinitely. There is no timeout.

Arithmetic and indexing:
- R*C is computed at 8 bits; with 4-bit fields no overflow is possible.
- idx is wide enough for MAX_ELEMS-1.
- Buffer entries beyond R*C remain 0.

Reset mid-operation:
- A partially loaded operand set is discarded.
- readybit drops immediately, asynchronously, and never reasserts until a complete new load finishes.

Simultaneous events:
- startbit outside PRESENT is ignored.
- in_valid in PRESENT is not accepted; the upstream source must hold its word until in_ready rises.

Test Plan:
1. Reset, then send header 0x2222 and elements 1,2,3,4,5,6,7,8 with in_valid held continuously:
   - R1=C1=R2=C2=2;
   - flat_matrix_1={1,2,3,4}, flat_matrix_2={5,6,7,8};
   - readybit rises 1 cycle after the 8th transfer;
   - in_ready=0 while readybit is high.
2. Continuing from 1, hold startbit=0 for 10 cycles, then pulse it for 1 cycle:
   - readybit stays high for all 10 cycles;
   - readybit drops the cycle after the startbit edge;
   - in_ready=1; buffers are still {1,2,3,4}/{5,6,7,8}.
3. Send header 0x1221 (R1=1, C1=2, R2=2, C2=1), then elements 9,10,11,12:
   - flat_matrix_1={9,10,0,0}, flat_matrix_2={11,12,0,0};
   - readybit asserted.
4. Send header 0x2232 (C1=3 != R2=2, and R1*C1=6 > 4):
   - hdr_err pulses for 1 cycle;
   - state stays IDLE; previous outputs are unchanged;
   - a following header 0x1111 plus elements 7 and 3 loads correctly.
5. Send header 0x2222 and 3 elements with in_valid toggling every cycle, then assert RST_N=0 mid-stream:
   - all outputs go to 0 immediately;
   - after release, a full reload behaves as in scenario 1.
6. Send a header with in_valid low for 5 cycles between each element:
   - no spurious writes occur;
   - final buffers match the transferred words exactly.

Source files
------------

// File: rtl/matrix_loader_if.sv
// Stream-in / operand-out bundle between the upstream source, the matrix loader
// and the matrix multiplier. The loader uses the slave view; the driving side uses master.
interface matrix_loader_if #(
  parameter int DATA_W    = 32,
  parameter int MAX_ELEMS = 4
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] flat_matrix_1 [0:MAX_ELEMS-1];
  logic [DATA_W-1:0] flat_matrix_2 [0:MAX_ELEMS-1];
  logic [3:0]        R1;
  logic [3:0]        C1;
  logic [3:0]        R2;
  logic [3:0]        C2;
  logic              readybit;
  logic              startbit;
  logic              hdr_err;
  logic              busy;

  modport slave (
    input  in_data, in_valid, startbit,
    output in_ready, flat_matrix_1, flat_matrix_2, R1, C1, R2, C2,
           readybit, hdr_err, busy
  );

  modport master (
    output in_data, in_valid, startbit,
    input  in_ready, flat_matrix_1, flat_matrix_2, R1, C1, R2, C2,
           readybit, hdr_err, busy
  );
endinterface

// File: rtl/matrix_loader.sv
// Collects a header plus two row-major matrices from a valid/ready word stream
// and presents them, held stable, to the multiplier until it acknowledges.
module matrix_loader #(
  parameter int DATA_W    = 32,
  parameter int MAX_ELEMS = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  matrix_loader_if.slave   bus
);

  localparam int          IDX_W = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1;
  localparam logic [7:0]  MAX_E = 8'(MAX_ELEMS);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD1   = 2'd1;
  localparam logic [1:0] LOAD2   = 2'd2;
  localparam logic [1:0] PRESENT = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        r1_q, r1_d, c1_q, c1_d, r2_q, r2_d, c2_q, c2_d;
  logic [DATA_W-1:0] buf1_q [0:MAX_ELEMS-1];
  logic [DATA_W-1:0] buf1_d [0:MAX_ELEMS-1];
  logic [DATA_W-1:0] buf2_q [0:MAX_ELEMS-1];
  logic [DATA_W-1:0] buf2_d [0:MAX_ELEMS-1];
  logic              in_ready_q, in_ready_d;
  logic              readybit_q, readybit_d;
  logic              hdr_err_q, hdr_err_d;

  logic              xfer;
  logic [7:0]        n1, n2, idx_ext;

  function automatic logic [7:0] prod8(input logic [3:0] a, input logic [3:0] b);
    return {4'd0, a} * {4'd0, b};
  endfunction

  function automatic logic hdr_ok(input logic [15:0] h);
    logic [3:0] r1, c1, r2, c2;
    r1 = h[3:0];
    c1 = h[7:4];
    r2 = h[11:8];
    c2 = h[15:12];
    return (r1 != 4'd0) && (c1 != 4'd0) && (r2 != 4'd0) && (c2 != 4'd0) &&
           (prod8(r1, c1) <= MAX_E) && (prod8(r2, c2) <= MAX_E) && (c1 == r2);
  endfunction

  assign xfer    = bus.in_valid && in_ready_q;
  assign n1      = prod8(r1_q, c1_q);
  assign n2      = prod8(r2_q, c2_q);
  assign idx_ext = 8'(idx_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    r1_d      = r1_q;
    c1_d      = c1_q;
    r2_d      = r2_q;
    c2_d      = c2_q;
    buf1_d    = buf1_q;
    buf2_d    = buf2_q;
    hdr_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (hdr_ok(bus.in_data[15:0])) begin
            r1_d  = bus.in_data[3:0];
            c1_d  = bus.in_data[7:4];
            r2_d  = bus.in_data[11:8];
            c2_d  = bus.in_data[15:12];
            for (int i = 0; i < MAX_ELEMS; i++) begin
              buf1_d[i] = '0;
              buf2_d[i] = '0;
            end
            idx_d   = '0;
            state_d = LOAD1;
          end else begin
            // Rejected header: outputs keep the last good operand set.
            hdr_err_d = 1'b1;
          end
        end
      end

      LOAD1: begin
        if (xfer) begin
          buf1_d[idx_q] = bus.in_data;
          if (idx_ext == n1 - 8'd1) begin
            idx_d   = '0;
            state_d = LOAD2;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      LOAD2: begin
        if (xfer) begin
          buf2_d[idx_q] = bus.in_data;
          if (idx_ext == n2 - 8'd1) begin
            idx_d   = '0;
            state_d = PRESENT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      PRESENT: begin
        if (bus.startbit) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they line up with it.
  assign in_ready_d = (state_d != PRESENT);
  assign readybit_d = (state_d == PRESENT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      r1_q       <= '0;
      c1_q       <= '0;
      r2_q       <= '0;
      c2_q       <= '0;
      in_ready_q <= 1'b0;
      readybit_q <= 1'b0;
      hdr_err_q  <= 1'b0;
      for (int i = 0; i < MAX_ELEMS; i++) begin
        buf1_q[i] <= '0;
        buf2_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      r1_q       <= r1_d;
      c1_q       <= c1_d;
      r2_q       <= r2_d;
      c2_q       <= c2_d;
      in_ready_q <= in_ready_d;
      readybit_q <= readybit_d;
      hdr_err_q  <= hdr_err_d;
      for (int i = 0; i < MAX_ELEMS; i++) begin
        buf1_q[i] <= buf1_d[i];
        buf2_q[i] <= buf2_d[i];
      end
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.readybit      = readybit_q;
  assign bus.hdr_err       = hdr_err_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.R1            = r1_q;
  assign bus.C1            = c1_q;
  assign bus.R2            = r2_q;
  assign bus.C2            = c2_q;
  assign bus.flat_matrix_1 = buf1_q;
  assign bus.flat_matrix_2 = buf2_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: expected operand sets are queued as loads
// are driven and compared when readybit rises.
module tb_matrix_loader;

  localparam int DATA_W    = 32;
  localparam int MAX_ELEMS = 4;

  logic CLK;
  logic RST_N;

  matrix_loader_if #(.DATA_W(DATA_W), .MAX_ELEMS(MAX_ELEMS)) bus ();

  matrix_loader #(.DATA_W(DATA_W), .MAX_ELEMS(MAX_ELEMS)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]       r1, c1, r2, c2;
    logic [3:0][31:0] m1;
    logic [3:0][31:0] m2;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  logic rb_prev  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Compare the presented operand set against the oldest queued expectation.
  always @(negedge CLK) begin
    if (bus.readybit === 1'b1 && rb_prev === 1'b0) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_R1", 32'(bus.R1), 32'(e.r1));
        chk("sb_C1", 32'(bus.C1), 32'(e.c1));
        chk("sb_R2", 32'(bus.R2), 32'(e.r2));
        chk("sb_C2", 32'(bus.C2), 32'(e.c2));
        for (int i = 0; i < MAX_ELEMS; i++) begin
          chk($sformatf("sb_m1[%0d]", i), bus.flat_matrix_1[i], e.m1[i]);
          chk($sformatf("sb_m2[%0d]", i), bus.flat_matrix_2[i], e.m2[i]);
        end
      end
    end
    rb_prev = bus.readybit;
  end

  // Drive one word; returns at the negedge following its transfer.
  task automatic send(input logic [31:0] w, input int gap);
    int n;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic do_load(input logic [15:0] hdr, input logic [7:0][31:0] el, input int gap);
    exp_t e;
    int   n1, n2;
    n1   = int'(hdr[3:0]) * int'(hdr[7:4]);
    n2   = int'(hdr[11:8]) * int'(hdr[15:12]);
    e.r1 = hdr[3:0];
    e.c1 = hdr[7:4];
    e.r2 = hdr[11:8];
    e.c2 = hdr[15:12];
    for (int i = 0; i < 4; i++) begin
      e.m1[i] = (i < n1) ? el[i] : 32'd0;
      e.m2[i] = (i < n2) ? el[n1 + i] : 32'd0;
    end
    sb_q.push_back(e);
    send({16'hABCD, hdr}, gap);
    for (int i = 0; i < n1 + n2; i++) send(el[i], gap);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.readybit !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("wait_readybit", 32'(bus.readybit), 32'd1);
  endtask

  task automatic ack();
    bus.startbit = 1'b1;
    @(negedge CLK);
    bus.startbit = 1'b0;
    chk("ack_readybit", 32'(bus.readybit), 32'd0);
    chk("ack_in_ready", 32'(bus.in_ready), 32'd1);
    chk("ack_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_readybit"}, 32'(bus.readybit), 32'd0);
    chk({tag, "_hdr_err"}, 32'(bus.hdr_err), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_dims"}, {16'd0, bus.C2, bus.R2, bus.C1, bus.R1}, 32'd0);
    for (int i = 0; i < MAX_ELEMS; i++) begin
      chk($sformatf("%s_m1[%0d]", tag, i), bus.flat_matrix_1[i], 32'd0);
      chk($sformatf("%s_m2[%0d]", tag, i), bus.flat_matrix_2[i], 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0][31:0] el;
    RST_N        = 1'b1;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.startbit = 1'b0;
    #2 RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_outputs("rst");
    RST_N = 1'b1;
    chk("rst_release_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge CLK);
    chk("first_edge_in_ready", 32'(bus.in_ready), 32'd1);

    // 1: 2x2 by 2x2 with continuous valid
    el = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 8; i++) el[i] = 32'(i + 1);
    do_load(16'h2222, el, 0);
    chk("s1_readybit", 32'(bus.readybit), 32'd1);
    chk("s1_in_ready", 32'(bus.in_ready), 32'd0);
    chk("s1_busy", 32'(bus.busy), 32'd1);

    // 2: long wait with startbit low, then acknowledge
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("s2_hold_readybit", 32'(bus.readybit), 32'd1);
      chk("s2_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    ack();
    for (int i = 0; i < 4; i++) begin
      chk("s2_keep_m1", bus.flat_matrix_1[i], 32'(i + 1));
      chk("s2_keep_m2", bus.flat_matrix_2[i], 32'(i + 5));
    end

    // 3: 1x2 by 2x1
    el = '0;
    el[0] = 32'd9; el[1] = 32'd10; el[2] = 32'd11; el[3] = 32'd12;
    do_load(16'h1221, el, 0);
    chk("s3_readybit", 32'(bus.readybit), 32'd1);
    ack();

    // 4: rejected header, then a 1x1 load
    send(32'h0000_2232, 0);
    chk("s4_hdr_err", 32'(bus.hdr_err), 32'd1);
    chk("s4_busy", 32'(bus.busy), 32'd0);
    chk("s4_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge CLK);
    chk("s4_hdr_err_clear", 32'(bus.hdr_err), 32'd0);
    chk("s4_dims_kept", {16'd0, bus.C2, bus.R2, bus.C1, bus.R1}, 32'h0000_1221);
    chk("s4_m1_kept", bus.flat_matrix_1[1], 32'd10);
    chk("s4_m2_kept", bus.flat_matrix_2[0], 32'd11);
    el = '0;
    el[0] = 32'd7; el[1] = 32'd3;
    do_load(16'h1111, el, 0);
    wait_ready();
    ack();

    // 5: partial load with toggling valid, then asynchronous reset
    send(32'h0000_2222, 1);
    send(32'd101, 1);
    send(32'd102, 1);
    send(32'd103, 0);
    chk("s5_busy_midload", 32'(bus.busy), 32'd1);
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("s5_rst");
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    el = '0;
    for (int i = 0; i < 8; i++) el[i] = 32'(i + 1);
    do_load(16'h2222, el, 0);
    chk("s5_reload_readybit", 32'(bus.readybit), 32'd1);
    ack();

    // 6: 2x1 by 1x2 with long idle gaps between words
    el = '0;
    el[0] = 32'hDEAD_0001; el[1] = 32'hDEAD_0002;
    el[2] = 32'hBEEF_0003; el[3] = 32'hBEEF_0004;
    do_load(16'h2112, el, 5);
    wait_ready();
    ack();

    // startbit outside PRESENT must not disturb IDLE
    bus.startbit = 1'b1;
    @(negedge CLK);
    bus.startbit = 1'b0;
    chk("idle_start_busy", 32'(bus.busy), 32'd0);
    chk("idle_start_readybit", 32'(bus.readybit), 32'd0);

    repeat (3) @(negedge CLK);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
